// File: rtl/sys1_video_pkg.sv
// Shared raster geometry for the arcade video path: default constants, the
// per-axis timing struct and a helper that sums it into a total count.
package sys1_video_pkg;

   localparam int unsigned CNT_W     = 9;
   localparam int unsigned MAX_TOTAL = 512;

   localparam int unsigned DEF_H_ACTIVE = 256;
   localparam int unsigned DEF_H_FP     = 40;
   localparam int unsigned DEF_H_SYNC   = 32;
   localparam int unsigned DEF_H_BP     = 56;
   localparam int unsigned DEF_V_ACTIVE = 224;
   localparam int unsigned DEF_V_FP     = 3;
   localparam int unsigned DEF_V_SYNC   = 7;
   localparam int unsigned DEF_V_BP     = 29;

   typedef struct packed {
      logic [9:0] active;
      logic [9:0] fp;
      logic [9:0] sync;
      logic [9:0] bp;
   } timing_t;

   function automatic int unsigned timing_total(timing_t t);
      return 32'(t.active) + 32'(t.fp) + 32'(t.sync) + 32'(t.bp);
   endfunction

endpackage

// File: rtl/sync_axis.sv
// One raster axis: position counter, blank/sync decode and the sync-shift latch.
// Used twice, horizontal stepped by the pixel enable and vertical by the line wrap.
module sync_axis
   import sys1_video_pkg::*;
#(
   parameter timing_t     TIM   = '{active: 10'(DEF_H_ACTIVE), fp: 10'(DEF_H_FP),
                                    sync: 10'(DEF_H_SYNC), bp: 10'(DEF_H_BP)},
   parameter int unsigned ADJ_W = 4
) (
   input  logic                    i_clk,
   input  logic                    i_reset,
   input  logic                    i_step,
   input  logic                    i_latch,
   input  logic signed [ADJ_W-1:0] i_adj,
   output logic [CNT_W-1:0]        o_cnt,
   output logic                    o_blank,
   output logic                    o_sync,
   output logic                    o_wrap
);

   localparam int unsigned TOTAL = timing_total(TIM);
   localparam logic [9:0]  SYNC0 = TIM.active + TIM.fp;

   logic [CNT_W-1:0]        r_cnt;
   logic signed [ADJ_W-1:0] r_adj;
   logic                    w_last;
   logic signed [9:0]       w_cnt;
   logic signed [9:0]       w_adj;
   logic signed [9:0]       w_sync_lo;
   logic signed [9:0]       w_sync_hi;

   assign w_last = ({1'b0, r_cnt} == 10'(TOTAL - 1));
   assign o_wrap = i_step && w_last;
   assign o_cnt  = r_cnt;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_cnt <= '0;
         r_adj <= '0;
      end else begin
         if (i_step) begin
            r_cnt <= w_last ? '0 : r_cnt + 9'd1;
         end
         // Shift is sampled only at the frame boundary so a frame never tears.
         if (i_latch) begin
            r_adj <= i_adj;
         end
      end
   end

   assign w_cnt     = $signed({1'b0, r_cnt});
   assign w_adj     = {{(10 - ADJ_W){r_adj[ADJ_W-1]}}, r_adj};
   assign w_sync_lo = $signed(SYNC0) + w_adj;
   assign w_sync_hi = w_sync_lo + $signed(TIM.sync);

   assign o_blank = (w_cnt >= $signed(TIM.active));
   assign o_sync  = (w_cnt >= w_sync_lo) && (w_cnt < w_sync_hi);

endmodule

// File: rtl/video_timing_gen.sv
// Configurable raster timing generator: chains the horizontal and vertical axes
// and registers blank, sync, gated pixel data and line/frame pulses.
module video_timing_gen
   import sys1_video_pkg::*;
#(
   parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
   parameter int unsigned H_FP     = DEF_H_FP,
   parameter int unsigned H_SYNC   = DEF_H_SYNC,
   parameter int unsigned H_BP     = DEF_H_BP,
   parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
   parameter int unsigned V_FP     = DEF_V_FP,
   parameter int unsigned V_SYNC   = DEF_V_SYNC,
   parameter int unsigned V_BP     = DEF_V_BP,
   parameter int          HPOS_OFS = 0,
   parameter int unsigned RGB_W    = 8
) (
   input  logic              clk48M,
   input  logic              reset,
   input  logic              pce,
   input  logic signed [3:0] h_adj,
   input  logic signed [1:0] v_adj,
   input  logic [RGB_W-1:0]  irgb,
   output logic [8:0]        hpos,
   output logic [8:0]        vpos,
   output logic [RGB_W-1:0]  orgb,
   output logic              hblank,
   output logic              vblank,
   output logic              hsync_n,
   output logic              vsync_n,
   output logic              line_start,
   output logic              frame_start
);

   localparam timing_t H_TIM = '{active: 10'(H_ACTIVE), fp: 10'(H_FP),
                                 sync: 10'(H_SYNC), bp: 10'(H_BP)};
   localparam timing_t V_TIM = '{active: 10'(V_ACTIVE), fp: 10'(V_FP),
                                 sync: 10'(V_SYNC), bp: 10'(V_BP)};
   localparam int unsigned HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

   // Porch minimums guarantee the shifted sync never leaves blanking.
   if (H_FP < 8 || H_BP < 8 || V_FP < 2 || V_BP < 2 || HT > MAX_TOTAL || VT > MAX_TOTAL)
   begin : g_geometry_err
      $error("video_timing_gen: illegal raster geometry");
   end

   logic [8:0]       w_hcnt;
   logic [8:0]       w_vcnt;
   logic             w_hblank;
   logic             w_vblank;
   logic             w_hsync;
   logic             w_vsync;
   logic             w_h_wrap;
   logic             w_v_wrap;

   logic [RGB_W-1:0] r_orgb;
   logic             r_hblank;
   logic             r_vblank;
   logic             r_hsync_n;
   logic             r_vsync_n;
   logic             r_line_start;
   logic             r_frame_start;

   sync_axis #(
      .TIM   (H_TIM),
      .ADJ_W (4)
   ) u_h_axis (
      .i_clk   (clk48M),
      .i_reset (reset),
      .i_step  (pce),
      .i_latch (w_v_wrap),
      .i_adj   (h_adj),
      .o_cnt   (w_hcnt),
      .o_blank (w_hblank),
      .o_sync  (w_hsync),
      .o_wrap  (w_h_wrap)
   );

   sync_axis #(
      .TIM   (V_TIM),
      .ADJ_W (2)
   ) u_v_axis (
      .i_clk   (clk48M),
      .i_reset (reset),
      .i_step  (w_h_wrap),
      .i_latch (w_v_wrap),
      .i_adj   (v_adj),
      .o_cnt   (w_vcnt),
      .o_blank (w_vblank),
      .o_sync  (w_vsync),
      .o_wrap  (w_v_wrap)
   );

   always_ff @(posedge clk48M) begin
      if (reset) begin
         r_orgb        <= '0;
         r_hblank      <= 1'b1;
         r_vblank      <= 1'b1;
         r_hsync_n     <= 1'b1;
         r_vsync_n     <= 1'b1;
         r_line_start  <= 1'b0;
         r_frame_start <= 1'b0;
      end else begin
         r_line_start  <= w_h_wrap;
         r_frame_start <= w_v_wrap;
         if (pce) begin
            r_orgb    <= (w_hblank || w_vblank) ? '0 : irgb;
            r_hblank  <= w_hblank;
            r_vblank  <= w_vblank;
            r_hsync_n <= ~w_hsync;
            r_vsync_n <= ~w_vsync;
         end
      end
   end

   // Modulo-512 add gives the wrapped coordinate for negative offsets.
   assign hpos        = w_hcnt + 9'(HPOS_OFS);
   assign vpos        = w_vcnt;
   assign orgb        = r_orgb;
   assign hblank      = r_hblank;
   assign vblank      = r_vblank;
   assign hsync_n     = r_hsync_n;
   assign vsync_n     = r_vsync_n;
   assign line_start  = r_line_start;
   assign frame_start = r_frame_start;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen on a small raster: a pixel-index reference model
// predicts every output under random pixel-enable spacing and pixel data.
module tb_video_timing_gen;

   localparam int HA  = 16;
   localparam int HFP = 8;
   localparam int HS  = 4;
   localparam int HBP = 8;
   localparam int VA  = 6;
   localparam int VFP = 2;
   localparam int VS  = 2;
   localparam int VBP = 2;
   localparam int OFS = -16;
   localparam int HT  = HA + HFP + HS + HBP;
   localparam int VT  = VA + VFP + VS + VBP;
   localparam int FT  = HT * VT;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              pce = 1'b0;
   logic signed [3:0] h_adj = '0;
   logic signed [1:0] v_adj = '0;
   logic [7:0]        irgb = '0;
   logic [8:0]        hpos;
   logic [8:0]        vpos;
   logic [7:0]        orgb;
   logic              hblank;
   logic              vblank;
   logic              hsync_n;
   logic              vsync_n;
   logic              line_start;
   logic              frame_start;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference state: linear pixel index within the frame plus latched shifts.
   int         p = 0;
   int         adj_h_l = 0;
   int         adj_v_l = 0;
   int         last_hc = 0;
   int         last_vc = 0;
   logic       exp_hblank, exp_vblank, exp_hsync_n, exp_vsync_n, exp_ls, exp_fs;
   logic [7:0] exp_orgb;

   video_timing_gen #(
      .H_ACTIVE (HA),
      .H_FP     (HFP),
      .H_SYNC   (HS),
      .H_BP     (HBP),
      .V_ACTIVE (VA),
      .V_FP     (VFP),
      .V_SYNC   (VS),
      .V_BP     (VBP),
      .HPOS_OFS (OFS),
      .RGB_W    (8)
   ) dut (
      .clk48M      (clk),
      .reset       (reset),
      .pce         (pce),
      .h_adj       (h_adj),
      .v_adj       (v_adj),
      .irgb        (irgb),
      .hpos        (hpos),
      .vpos        (vpos),
      .orgb        (orgb),
      .hblank      (hblank),
      .vblank      (vblank),
      .hsync_n     (hsync_n),
      .vsync_n     (vsync_n),
      .line_start  (line_start),
      .frame_start (frame_start)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [8:0] exp_hpos();
      int h;
      h = (p % HT) + OFS;
      if (h < 0) h += 512;
      return 9'(h);
   endfunction

   // Drive one clock cycle and advance the reference model alongside it.
   task automatic advance(input bit do_pce, input logic [7:0] rgb);
      int hc, vc, hs0, vs0;
      hc   = p % HT;
      vc   = p / HT;
      irgb = rgb;
      pce  = do_pce;
      if (do_pce) begin
         hs0         = HA + HFP + adj_h_l;
         vs0         = VA + VFP + adj_v_l;
         exp_hblank  = (hc >= HA);
         exp_vblank  = (vc >= VA);
         exp_hsync_n = !((hc >= hs0) && (hc < hs0 + HS));
         exp_vsync_n = !((vc >= vs0) && (vc < vs0 + VS));
         exp_orgb    = (exp_hblank || exp_vblank) ? 8'h00 : rgb;
         exp_ls      = (hc == HT - 1);
         exp_fs      = (p == FT - 1);
         if (exp_fs) begin
            adj_h_l = int'(h_adj);
            adj_v_l = int'(v_adj);
         end
         last_hc = hc;
         last_vc = vc;
         p = (p + 1) % FT;
      end else begin
         exp_ls = 1'b0;
         exp_fs = 1'b0;
      end
      @(posedge clk);
      #1;
      pce = 1'b0;
   endtask

   task automatic pce_step(input logic [7:0] rgb);
      repeat ($urandom_range(0, 2)) advance(1'b0, rgb);
      advance(1'b1, rgb);
   endtask

   task automatic apply_reset(input bit with_pce);
      reset = 1'b1;
      pce   = with_pce;
      irgb  = 8'($urandom);
      @(posedge clk);
      #1;
      reset       = 1'b0;
      pce         = 1'b0;
      p           = 0;
      adj_h_l     = 0;
      adj_v_l     = 0;
      exp_hblank  = 1'b1;
      exp_vblank  = 1'b1;
      exp_hsync_n = 1'b1;
      exp_vsync_n = 1'b1;
      exp_orgb    = 8'h00;
      exp_ls      = 1'b0;
      exp_fs      = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset(1'b1);
      n_tests++; if (hblank !== 1'b1) begin n_fail++; $display("FAIL reset_hblank got %b want 1", hblank); end
      n_tests++; if (vblank !== 1'b1) begin n_fail++; $display("FAIL reset_vblank got %b want 1", vblank); end
      n_tests++; if (hsync_n !== 1'b1) begin n_fail++; $display("FAIL reset_hsync_n got %b want 1", hsync_n); end
      n_tests++; if (vsync_n !== 1'b1) begin n_fail++; $display("FAIL reset_vsync_n got %b want 1", vsync_n); end
      n_tests++; if (orgb !== 8'h00) begin n_fail++; $display("FAIL reset_orgb got %h want 00", orgb); end
      n_tests++; if (line_start !== 1'b0) begin n_fail++; $display("FAIL reset_line_start got %b want 0", line_start); end
      n_tests++; if (frame_start !== 1'b0) begin n_fail++; $display("FAIL reset_frame_start got %b want 0", frame_start); end
      n_tests++; if (hpos !== 9'd496) begin n_fail++; $display("FAIL reset_hpos got %0d want 496", hpos); end
      n_tests++; if (vpos !== 9'd0) begin n_fail++; $display("FAIL reset_vpos got %0d want 0", vpos); end
   endtask

   task automatic test_hpos_ofs();
      n_tests++; if (hpos !== 9'd496) begin n_fail++; $display("FAIL hpos_at_0 got %0d want 496", hpos); end
      repeat (16) pce_step(8'($urandom));
      n_tests++; if (hpos !== 9'd0) begin n_fail++; $display("FAIL hpos_at_16 got %0d want 0", hpos); end
      n_tests++; if (vpos !== 9'd0) begin n_fail++; $display("FAIL vpos_at_16 got %0d want 0", vpos); end
   endtask

   task automatic test_raster(input int frames);
      int  k = 0;
      int  fs_cnt = 0;
      int  ls_cnt = 0;
      bit  dp;
      h_adj = '0;
      v_adj = '0;
      while (k < frames * FT) begin
         dp = ($urandom_range(0, 2) != 0);
         advance(dp, 8'($urandom));
         if (dp) k++;
         if (line_start === 1'b1) ls_cnt++;
         if (frame_start === 1'b1) fs_cnt++;
         n_tests++; if (hpos !== exp_hpos()) begin n_fail++; $display("FAIL raster_hpos p=%0d got %0d want %0d", p, hpos, exp_hpos()); end
         n_tests++; if (vpos !== 9'(p / HT)) begin n_fail++; $display("FAIL raster_vpos p=%0d got %0d want %0d", p, vpos, p / HT); end
         n_tests++; if (hblank !== exp_hblank) begin n_fail++; $display("FAIL raster_hblank p=%0d got %b want %b", p, hblank, exp_hblank); end
         n_tests++; if (vblank !== exp_vblank) begin n_fail++; $display("FAIL raster_vblank p=%0d got %b want %b", p, vblank, exp_vblank); end
         n_tests++; if (hsync_n !== exp_hsync_n) begin n_fail++; $display("FAIL raster_hsync_n p=%0d got %b want %b", p, hsync_n, exp_hsync_n); end
         n_tests++; if (vsync_n !== exp_vsync_n) begin n_fail++; $display("FAIL raster_vsync_n p=%0d got %b want %b", p, vsync_n, exp_vsync_n); end
         n_tests++; if (orgb !== exp_orgb) begin n_fail++; $display("FAIL raster_orgb p=%0d got %h want %h", p, orgb, exp_orgb); end
         n_tests++; if (line_start !== exp_ls) begin n_fail++; $display("FAIL raster_line_start p=%0d got %b want %b", p, line_start, exp_ls); end
         n_tests++; if (frame_start !== exp_fs) begin n_fail++; $display("FAIL raster_frame_start p=%0d got %b want %b", p, frame_start, exp_fs); end
      end
      n_tests++; if (ls_cnt !== frames * VT) begin n_fail++; $display("FAIL raster_line_count got %0d want %0d", ls_cnt, frames * VT); end
      n_tests++; if (fs_cnt !== frames) begin n_fail++; $display("FAIL raster_frame_count got %0d want %0d", fs_cnt, frames); end
   endtask

   task automatic test_orgb();
      logic [7:0] want;
      repeat (FT) begin
         pce_step(8'hA5);
         want = (last_hc < HA && last_vc < VA) ? 8'hA5 : 8'h00;
         n_tests++; if (orgb !== want) begin n_fail++; $display("FAIL orgb_gate hc=%0d vc=%0d got %h want %h", last_hc, last_vc, orgb, want); end
      end
   endtask

   task automatic test_hadj_midframe();
      int lo0 = 999, hi0 = -1, lo1 = 999, hi1 = -1;
      h_adj = '0;
      v_adj = '0;
      repeat (FT - p) pce_step(8'($urandom));
      for (int i = 0; i < FT; i++) begin
         if (i == FT / 2) h_adj = -4'sd8;
         pce_step(8'($urandom));
         n_tests++; if (hsync_n !== exp_hsync_n) begin n_fail++; $display("FAIL hadj_hsync_n hc=%0d got %b want %b", last_hc, hsync_n, exp_hsync_n); end
         if (hsync_n === 1'b0) begin
            if (last_hc < lo0) lo0 = last_hc;
            if (last_hc > hi0) hi0 = last_hc;
         end
      end
      n_tests++; if (frame_start !== 1'b1) begin n_fail++; $display("FAIL hadj_frame_start got %b want 1", frame_start); end
      repeat (2 * HT) begin
         pce_step(8'($urandom));
         if (hsync_n === 1'b0) begin
            if (last_hc < lo1) lo1 = last_hc;
            if (last_hc > hi1) hi1 = last_hc;
         end
      end
      n_tests++; if (lo0 !== HA + HFP || hi0 !== HA + HFP + HS - 1) begin n_fail++; $display("FAIL hadj_old_window got %0d..%0d want %0d..%0d", lo0, hi0, HA + HFP, HA + HFP + HS - 1); end
      n_tests++; if (lo1 !== HA + HFP - 8 || hi1 !== HA + HFP + HS - 9) begin n_fail++; $display("FAIL hadj_new_window got %0d..%0d want %0d..%0d", lo1, hi1, HA + HFP - 8, HA + HFP + HS - 9); end
      h_adj = '0;
   endtask

   task automatic test_vadj(input int adj);
      int lo = 999, hi = -1;
      v_adj = 2'(adj);
      repeat (FT - p) pce_step(8'($urandom));
      n_tests++; if (frame_start !== 1'b1) begin n_fail++; $display("FAIL vadj_frame_start adj=%0d got %b want 1", adj, frame_start); end
      repeat (FT) begin
         pce_step(8'($urandom));
         n_tests++; if (vsync_n !== exp_vsync_n) begin n_fail++; $display("FAIL vadj_vsync_n vc=%0d got %b want %b", last_vc, vsync_n, exp_vsync_n); end
         if (vsync_n === 1'b0) begin
            if (last_vc < lo) lo = last_vc;
            if (last_vc > hi) hi = last_vc;
            n_tests++; if (vblank !== 1'b1) begin n_fail++; $display("FAIL vadj_in_vblank vc=%0d got %b want 1", last_vc, vblank); end
         end
      end
      n_tests++; if (lo !== VA + VFP + adj || hi !== VA + VFP + adj + VS - 1) begin n_fail++; $display("FAIL vadj_window adj=%0d got %0d..%0d want %0d..%0d", adj, lo, hi, VA + VFP + adj, VA + VFP + adj + VS - 1); end
      v_adj = '0;
   endtask

   task automatic test_reset_midline();
      int target = 4 * HT + 20;
      repeat ((target - p + FT) % FT) pce_step(8'($urandom));
      n_tests++; if (hpos !== 9'd4 || vpos !== 9'd4) begin n_fail++; $display("FAIL midline_position got %0d,%0d want 4,4", hpos, vpos); end
      apply_reset(1'b1);
      n_tests++; if (hpos !== 9'd496 || vpos !== 9'd0) begin n_fail++; $display("FAIL midline_reset_pos got %0d,%0d want 496,0", hpos, vpos); end
      n_tests++; if (hblank !== 1'b1 || vblank !== 1'b1) begin n_fail++; $display("FAIL midline_reset_blank got %b%b want 11", hblank, vblank); end
      n_tests++; if (hsync_n !== 1'b1 || vsync_n !== 1'b1 || orgb !== 8'h00) begin n_fail++; $display("FAIL midline_reset_sync_rgb got %b%b %h want 11 00", hsync_n, vsync_n, orgb); end
      advance(1'b1, 8'h3C);
      n_tests++; if (hpos !== 9'd497) begin n_fail++; $display("FAIL midline_first_hpos got %0d want 497", hpos); end
      n_tests++; if (hblank !== 1'b0 || vblank !== 1'b0) begin n_fail++; $display("FAIL midline_first_blank got %b%b want 00", hblank, vblank); end
      n_tests++; if (hsync_n !== 1'b1 || vsync_n !== 1'b1) begin n_fail++; $display("FAIL midline_first_sync got %b%b want 11", hsync_n, vsync_n); end
      n_tests++; if (orgb !== 8'h3C) begin n_fail++; $display("FAIL midline_first_orgb got %h want 3c", orgb); end
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_hpos_ofs();
      test_raster(2);
      test_orgb();
      test_hadj_midframe();
      test_vadj(1);
      test_vadj(-2);
      test_reset_midline();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Parametrised raster timing generator for the arcade cores. It replaces the fixed-count HV generator with configurable horizontal and vertical geometry, a pixel clock-enable, and runtime sync centering. It drives the game core's pixel counters and gates the core's pixel data into blanked, sync-aligned video for the scaler/fx stage. Sub-pixel-clock timing is referenced to a single fast system clock.

## Interface
Parameters:
- `H_ACTIVE`, 256: visible pixels per line.
- `H_FP`, 40: front porch in pixels; must be ≥ 8.
- `H_SYNC`, 32: hsync width in pixels.
- `H_BP`, 56: back porch in pixels; must be ≥ 8.
- `V_ACTIVE`, 224: visible lines.
- `V_FP`, 3: front porch in lines; must be ≥ 2.
- `V_SYNC`, 7: vsync width in lines.
- `V_BP`, 29: back porch in lines; must be ≥ 2.
- `HPOS_OFS`, 0: signed offset added to `hpos` (the game core's pixel coordinate).
- `RGB_W`, 8: pixel data width.

Ports:
- `clk48M`, in, 1: the single clock.
- `reset`, in, 1: synchronous, active-high.
- `pce`, in, 1: pixel clock enable, one `clk48M` cycle wide.
- `h_adj`, in, 4: signed hsync shift, −8..+7 pixels.
- `v_adj`, in, 2: signed vsync shift, −2..+1 lines.
- `irgb`, in, RGB_W: pixel from the game core.
- `hpos`, out, 9: `hcnt + HPOS_OFS`, combinational from the counter.
- `vpos`, out, 9: `vcnt`.
- `orgb`, out, RGB_W: blanked pixel, registered.
- `hblank`, out, 1: registered horizontal blank.
- `vblank`, out, 1: registered vertical blank.
- `hsync_n`, out, 1: registered, active-low.
- `vsync_n`, out, 1: registered, active-low.
- `line_start`, out, 1: one-`clk48M` pulse at each line wrap.
- `frame_start`, out, 1: one-`clk48M` pulse at each frame wrap.

## Operation
- Totals are `HT = H_ACTIVE+H_FP+H_SYNC+H_BP` and `VT` (the equivalent vertical sum). Elaboration fails if a porch constraint is violated or if `HT` or `VT` exceeds 512.
- Counters: `hcnt` runs 0..HT−1. It advances only on `pce`. At HT−1 it wraps to 0 and `vcnt` advances. `vcnt` wraps from VT−1 to 0.
- Decode, from the current counters:
  - hblank when `hcnt ≥ H_ACTIVE`.
  - vblank when `vcnt ≥ V_ACTIVE`.
  - hsync when `HS0 ≤ hcnt < HS0+H_SYNC`, with `HS0 = H_ACTIVE+H_FP+h_adj_l`.
  - vsync when `VS0 ≤ vcnt < VS0+V_SYNC`, with `VS0 = V_ACTIVE+V_FP+v_adj_l`.
- `h_adj_l` and `v_adj_l` are copies of `h_adj` and `v_adj` latched on the `pce` where the frame wraps (hcnt=HT−1, vcnt=VT−1). Mid-frame changes to `h_adj`/`v_adj` take effect next frame. Porch constraints keep sync inside blanking, so no clamp is needed.
- `orgb` is `irgb` when neither blank decode is active, else 0.
- Arithmetic is 10-bit signed internally. Outputs `hpos`/`vpos` are truncated to 9 bits, so `hpos` wraps modulo 512 for a negative `HPOS_OFS`.

## Timing
- Reset: `hcnt`/`vcnt` = 0, adj latches = 0, `hblank`/`vblank`/`hsync_n`/`vsync_n` = 1, `orgb` = 0, pulses = 0. Reset overrides `pce` and takes effect in the same cycle.
- Latency:
  - Registered outputs change only on `pce` cycles and reflect the decode of the counter value present before the increment. The delay is exactly one `pce` behind `hpos`.
  - The game core must present `irgb` for `hpos` before the next `pce`.
- Pulses:
  - `line_start` asserts in the cycle after the `pce` that wraps `hcnt`.
  - `frame_start` asserts in the same cycle as `line_start`, when `vcnt` also wrapped.
  - Both deassert on the following `clk48M` cycle.
- Without `pce`, all state holds.
- Reset mid-line restarts at pixel 0, line 0. The first `pce` after reset yields active video and no sync.

## Structure
- The shared `sys1_video_pkg` holds the default geometry constants and a `timing_t` struct carrying active/fp/sync/bp.
- One natural sub-module: `sync_axis`, instantiated twice (horizontal/vertical). It contains the counter, the blank and sync decode, and the adj latch, with a `step` input and a `wrap` output. The top module chains h.wrap→v.step and registers the outputs.

## Test plan
- Defaults, `pce` every 8 clocks, one full frame → `hblank` falls at pixel 0 and rises after 256 pixels; line = 384 pixels; frame = 263 lines; exactly one `frame_start`.
- `h_adj`=0 → `hsync_n` low for pixels 296..327. Set `h_adj`=−8 mid-frame → unchanged until after `frame_start`, then low for 288..319.
- `v_adj`=+1 → `vsync_n` low for lines 228..234. `v_adj`=−2 → lines 225..231, still within vblank.
- `irgb`=8'hA5 held → `orgb`=A5 only in active area, 0 whenever `hblank` or `vblank`, aligned one `pce` after `hpos`.
- `HPOS_OFS`=−16 → `hpos`=496 at hcnt 0, `hpos`=0 at hcnt 16.
- Assert `reset` at hcnt=300, vcnt=100 → next cycle all outputs are at reset values; the first `pce` gives hcnt 0 → 1 and `hblank` 1→0.
